// File: rtl/div32_seq.sv
// Sequential signed 32-bit divider: sign/magnitude front end, unsigned restoring core
// producing one quotient bit per clock, registered result with a one-cycle ready pulse.
module div32_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_dvd;      // dividend shifts out the top while quotient bits shift in
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH:0]     r_rem;
    logic               r_sign_q;
    logic               r_dz;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH+1:0]   w_rem_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_q_next;
    logic [WIDTH-1:0]   w_q_signed;

    assign w_abs_a     = data_operandA[WIDTH-1] ? (~data_operandA + ONE) : data_operandA;
    assign w_abs_b     = data_operandB[WIDTH-1] ? (~data_operandB + ONE) : data_operandB;
    assign w_rem_shift = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge        = (w_rem_shift >= {2'b00, r_dvs});
    assign w_q_next    = {r_dvd[WIDTH-2:0], w_ge};
    assign w_q_signed  = r_sign_q ? (~w_q_next + ONE) : w_q_next;

    // NOTE: state and outputs use non-blocking assignments so every register samples
    // pre-edge values; a blocking write here would leak a new value into the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_dvd          <= '0;
            r_dvs          <= '0;
            r_rem          <= '0;
            r_sign_q       <= 1'b0;
            r_dz           <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else if (ctrl_DIV) begin
            // A start always wins, so a strobe during RUN silently abandons the old operation.
            r_state        <= S_RUN;
            r_cnt          <= '0;
            r_dvd          <= w_abs_a;
            r_dvs          <= w_abs_b;
            r_rem          <= '0;
            r_sign_q       <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_dz           <= (data_operandB == '0);
            data_resultRDY <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_rem <= w_ge ? (w_rem_shift[WIDTH:0] - {1'b0, r_dvs})
                                  : w_rem_shift[WIDTH:0];
                    r_dvd <= w_q_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state        <= S_DONE;
                        data_result    <= r_dz ? '0 : w_q_signed;
                        data_exception <= r_dz;
                        data_resultRDY <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state        <= S_IDLE;
                    data_resultRDY <= 1'b0;
                end
                default: begin
                    r_state        <= S_IDLE;
                    data_resultRDY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div32_seq.sv
// Self-checking bench for div32_seq: directed corner cases, abort/reset scenarios and
// randomized operands compared against a 64-bit arithmetic reference model.
module tb_div32_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_fail   = 0;

    div32_seq dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: signed division in 64-bit arithmetic, which truncates toward zero.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic exc);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == 32'd0) begin
            q   = 32'd0;
            exc = 1'b1;
        end else begin
            q   = 32'(sa / sb);
            exc = 1'b0;
        end
    endfunction

    // Called at a falling edge; ctrl_DIV is seen on the next `hold` rising edges.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        repeat (hold) @(negedge clock);
        ctrl_DIV      = 1'b0;
    endtask

    // Returns the number of rising edges after the last start edge until RDY is seen, or -1.
    task automatic wait_rdy(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
        int          lat;
        logic [31:0] exp_q;
        logic        exp_exc;
        ref_div(a, b, exp_q, exp_exc);
        wait_rdy(lat);
        check({tag, "_latency"}, 32'(lat), 32'd32);
        check({tag, "_result"}, data_result, exp_q);
        check({tag, "_exception"}, {31'd0, data_exception}, {31'd0, exp_exc});
        @(negedge clock);
        check({tag, "_rdy_pulse_end"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        start_op(a, b, 1);
        check_result(tag, a, b);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) pulses++;
        end
    endtask

    initial begin
        int          pulses;
        int          early;
        logic [31:0] ra;
        logic [31:0] rb;

        reset         = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (2) @(negedge clock);
        check("reset_result", data_result, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        run_op("pos_pos", 32'd100, 32'd7);
        run_op("neg_pos", 32'hFFFF_FF9C, 32'd7);
        run_op("neg_neg", 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        run_op("small_by_neg", 32'd7, 32'hFFFF_FF9C);
        run_op("div_zero", 32'd5, 32'd0);
        run_op("after_div_zero", 32'd6, 32'd3);
        run_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("min_by_two", 32'h8000_0000, 32'd2);
        run_op("zero_dividend", 32'd0, 32'd5);

        // Restart mid-RUN: only the second operation may report.
        start_op(32'd1000, 32'd10, 1);
        early = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY === 1'b1) early = 1;
        end
        start_op(32'd81, 32'd9, 1);
        check("abort_no_early_rdy", 32'(early), 32'd0);
        check_result("abort_restart", 32'd81, 32'd9);
        count_pulses(40, pulses);
        check("abort_single_pulse", 32'(pulses), 32'd0);

        // Strobe held for four edges: latency counts from the last one.
        start_op(32'd50, 32'd5, 4);
        check_result("held_start", 32'd50, 32'd5);

        // Asynchronous reset between edges while running.
        start_op(32'd1000, 32'd10, 1);
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        check("async_rst_result", data_result, 32'd0);
        check("async_rst_exception", {31'd0, data_exception}, 32'd0);
        check("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        count_pulses(40, pulses);
        check("async_rst_no_pulse", 32'(pulses), 32'd0);
        run_op("after_reset", 32'd1000, 32'd10);

        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 2))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(1, 1000));
                default: rb = -32'($urandom_range(1, 1000));
            endcase
            if (rb == 32'd0) rb = 32'd1;
            run_op("random", ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
